// File: rtl/ula_pkg.sv
// Shared opcodes, FSM state type and immediate constants for the sequential ALU.
package ula_pkg;

    localparam logic [4:0] OP_SLL   = 5'd0;
    localparam logic [4:0] OP_SRL   = 5'd1;
    localparam logic [4:0] OP_SRA   = 5'd2;
    localparam logic [4:0] OP_SLLV  = 5'd3;
    localparam logic [4:0] OP_SRLV  = 5'd4;
    localparam logic [4:0] OP_SRAV  = 5'd5;
    localparam logic [4:0] OP_ADD   = 5'd6;
    localparam logic [4:0] OP_SUB   = 5'd7;
    localparam logic [4:0] OP_AND   = 5'd8;
    localparam logic [4:0] OP_OR    = 5'd9;
    localparam logic [4:0] OP_XOR   = 5'd10;
    localparam logic [4:0] OP_NOR   = 5'd11;
    localparam logic [4:0] OP_SLT   = 5'd12;
    localparam logic [4:0] OP_SLTU  = 5'd13;
    localparam logic [4:0] OP_LUI   = 5'd14;
    localparam logic [4:0] OP_ORI   = 5'd15;
    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_MFHI  = 5'd20;
    localparam logic [4:0] OP_MFLO  = 5'd21;
    localparam logic [4:0] OP_MTHI  = 5'd22;
    localparam logic [4:0] OP_MTLO  = 5'd23;

    localparam int unsigned LUI_SHIFT = 16;
    localparam int unsigned IMM_W     = 16;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

endpackage

// File: rtl/ula_seq_if.sv
// Request/response bundle between the EX-stage control and the sequential ALU.
interface ula_seq_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
    logic                      start;
    logic [4:0]                OP;
    logic [WIDTH-1:0]          In1;
    logic [WIDTH-1:0]          In2;
    logic [SHAMT_W-1:0]        shamt;
    logic [ula_pkg::IMM_W-1:0] immediate;
    logic [WIDTH-1:0]          result;
    logic                      Zero_flag;
    logic                      busy;
    logic                      done;
    logic                      div_by_zero;

    modport master (
        output start, OP, In1, In2, shamt, immediate,
        input  result, Zero_flag, busy, done, div_by_zero
    );

    modport slave (
        input  start, OP, In1, In2, shamt, immediate,
        output result, Zero_flag, busy, done, div_by_zero
    );
endinterface

// File: rtl/ula_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with the sign fix-up applied combinationally to the finished registers.
module ula_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fin
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             run_q, div_q, neg_q, rneg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvs_q, acc_hi_q, acc_lo_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, shifted;
    logic             q_bit;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        a_neg = is_signed & a[WIDTH-1];
        b_neg = is_signed & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
        shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
        q_bit   = shifted >= {1'b0, dvs_q};

        if (div_q) begin
            // Partial remainder stays below the divisor, so WIDTH bits suffice after subtract.
            nxt_hi = q_bit ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo_q[WIDTH-2:0], q_bit};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
        end

        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? -prod : prod;
        if (div_q) begin
            hi = rneg_q ? -acc_hi_q : acc_hi_q;
            lo = neg_q ? -acc_lo_q : acc_lo_q;
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end

        fin = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q    <= 1'b0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            dvs_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else if (go) begin
            run_q    <= 1'b1;
            div_q    <= is_div;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            cnt_q    <= '0;
            dvs_q    <= b_mag;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
        end else if (run_q) begin
            acc_hi_q <= nxt_hi;
            acc_lo_q <= nxt_lo;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (fin) run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/ula_seq.sv
// Registered EX-stage ALU: single-cycle ops, HI/LO moves, and an iterative
// multiply/divide unit behind a start/busy/done handshake.
module ula_seq
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input logic      clock,
    input logic      reset,
    ula_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d;

    logic             go, is_div, is_signed;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             md_fin;
    logic [WIDTH-1:0] alu, imm_z;

    ula_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (bus.In1),
        .b         (bus.In2),
        .hi        (md_hi),
        .lo        (md_lo),
        .fin       (md_fin)
    );

    always_comb begin
        imm_z = WIDTH'(bus.immediate);
        alu   = '0;
        case (bus.OP)
            OP_SLL:  alu = bus.In2 << bus.shamt;
            OP_SRL:  alu = bus.In2 >> bus.shamt;
            OP_SRA:  alu = $signed(bus.In2) >>> bus.shamt;
            OP_SLLV: alu = bus.In2 << bus.In1[SHAMT_W-1:0];
            OP_SRLV: alu = bus.In2 >> bus.In1[SHAMT_W-1:0];
            OP_SRAV: alu = $signed(bus.In2) >>> bus.In1[SHAMT_W-1:0];
            OP_ADD:  alu = bus.In1 + bus.In2;
            OP_SUB:  alu = bus.In1 - bus.In2;
            OP_AND:  alu = bus.In1 & bus.In2;
            OP_OR:   alu = bus.In1 | bus.In2;
            OP_XOR:  alu = bus.In1 ^ bus.In2;
            OP_NOR:  alu = ~(bus.In1 | bus.In2);
            OP_SLT:  alu = WIDTH'($signed(bus.In1) < $signed(bus.In2));
            OP_SLTU: alu = WIDTH'(bus.In1 < bus.In2);
            OP_LUI:  alu = imm_z << LUI_SHIFT;
            OP_ORI:  alu = bus.In1 | imm_z;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        go        = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    case (bus.OP)
                        OP_MULT, OP_MULTU: begin
                            done_d    = 1'b0;
                            go        = 1'b1;
                            is_signed = (bus.OP == OP_MULT);
                            state_d   = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div    = 1'b1;
                            is_signed = (bus.OP == OP_DIV);
                            if (bus.In2 == '0) begin
                                hi_d     = bus.In1;
                                lo_d     = '1;
                                result_d = '1;
                                dbz_d    = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                go      = 1'b1;
                                state_d = DIV;
                            end
                        end
                        OP_MFHI: result_d = hi_q;
                        OP_MFLO: result_d = lo_q;
                        OP_MTHI: begin
                            hi_d     = bus.In1;
                            result_d = bus.In1;
                        end
                        OP_MTLO: begin
                            lo_d     = bus.In1;
                            result_d = bus.In1;
                        end
                        default: result_d = bus.OP[4] ? '0 : alu;
                    endcase
                end
            end
            MUL, DIV: begin
                if (md_fin) state_d = FIX;
            end
            FIX: begin
                hi_d     = md_hi;
                lo_d     = md_lo;
                result_d = md_lo;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.Zero_flag   = (result_q == '0);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule
